// File: rtl/dbg_pkg.sv
// dbg_pkg: shared record type, kind encoding and helpers for the commit-trace buffer
package dbg_pkg;

    localparam int GPR_AW   = 5;
    localparam int CSR_AW   = 12;
    localparam int XLEN_MAX = 64;

    typedef enum logic [1:0] {
        KIND_NORM = 2'd0,
        KIND_EBRK = 2'd1,
        KIND_IVD  = 2'd2
    } trace_kind_e;

    // Data fields are sized for the widest supported XLEN; narrower cores zero-extend.
    typedef struct packed {
        logic [XLEN_MAX-1:0] pc;
        logic [XLEN_MAX-1:0] inst;
        trace_kind_e         kind;
        logic                gpr_wen;
        logic [GPR_AW-1:0]   gpr_waddr;
        logic [XLEN_MAX-1:0] gpr_wdata;
        logic                csr_wen;
        logic [CSR_AW-1:0]   csr_waddr;
        logic [XLEN_MAX-1:0] csr_wdata;
    } trace_rec_t;

    // An invalid instruction outranks an ebreak on the same channel.
    function automatic trace_kind_e rec_kind(input logic brk, input logic ivd);
        return ivd ? KIND_IVD : (brk ? KIND_EBRK : KIND_NORM);
    endfunction

endpackage

// File: rtl/dbg_trace_fifo.sv
// dbg_trace_fifo: multi-write, single-read FIFO of trace records with occupancy count
module dbg_trace_fifo
    import dbg_pkg::*;
#(
    parameter int NCOMMIT = 2,
    parameter int DEPTH   = 16,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1),
    localparam int PW     = $clog2(NCOMMIT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  trace_rec_t    wr_rec_i [NCOMMIT],
    input  logic [PW-1:0] push_cnt_i,
    input  logic          pop_i,
    output trace_rec_t    rd_rec_o,
    output logic [CW-1:0] count_o
);

    trace_rec_t    mem [DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] cnt_q;
    logic          popped;

    assign popped   = pop_i && (cnt_q != '0);
    assign rd_rec_o = mem[rptr_q];
    assign count_o  = cnt_q;

    // record storage is deliberately left unreset; the first push_cnt ports land in consecutive slots
    always_ff @(posedge clk) begin
        for (int i = 0; i < NCOMMIT; i++)
            if (i < int'(push_cnt_i)) mem[wptr_q + AW'(i)] <= wr_rec_i[i];
    end

    // pointers wrap naturally at DEPTH; count tracks pushes minus pops
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            wptr_q <= wptr_q + AW'(push_cnt_i);
            rptr_q <= rptr_q + AW'(popped);
            cnt_q  <= cnt_q + CW'(push_cnt_i) - CW'(popped);
        end
    end

endmodule

// File: rtl/dbg_trace_buf.sv
// dbg_trace_buf: commit-trace capture with compaction, trap halt and retire/drop counters
module dbg_trace_buf
    import dbg_pkg::*;
#(
    parameter int NCOMMIT = 2,
    parameter int DEPTH   = 16,
    parameter int XLEN    = 32
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      trace_en,
    input  logic [NCOMMIT-1:0]        cmt_valid,
    input  logic [NCOMMIT*XLEN-1:0]   cmt_pc,
    input  logic [NCOMMIT*XLEN-1:0]   cmt_inst,
    input  logic [NCOMMIT-1:0]        cmt_brk,
    input  logic [NCOMMIT-1:0]        cmt_ivd,
    input  logic [NCOMMIT-1:0]        cmt_gpr_wen,
    input  logic [NCOMMIT*GPR_AW-1:0] cmt_gpr_waddr,
    input  logic [NCOMMIT*XLEN-1:0]   cmt_gpr_wdata,
    input  logic [NCOMMIT-1:0]        cmt_csr_wen,
    input  logic [NCOMMIT*CSR_AW-1:0] cmt_csr_waddr,
    input  logic [NCOMMIT*XLEN-1:0]   cmt_csr_wdata,
    output logic                      cmt_ready,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [XLEN-1:0]           out_inst,
    output logic [1:0]                out_kind,
    output logic                      out_gpr_wen,
    output logic [GPR_AW-1:0]         out_gpr_waddr,
    output logic [XLEN-1:0]           out_gpr_wdata,
    output logic                      out_csr_wen,
    output logic [CSR_AW-1:0]         out_csr_waddr,
    output logic [XLEN-1:0]           out_csr_wdata,
    output logic                      halted,
    output logic [1:0]                halt_reason,
    output logic [63:0]               instret,
    output logic [15:0]               drop_cnt,
    output logic                      overflow
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(NCOMMIT + 1);

    trace_rec_t    chan_rec [NCOMMIT];
    trace_rec_t    wr_rec   [NCOMMIT];
    trace_rec_t    head, head_m;
    logic [PW-1:0] n_keep, push_cnt;
    logic [CW-1:0] count;
    logic          trap_seen, active, accept, dropping;
    trace_kind_e   trap_kind;
    logic [16:0]   drop_sum;

    logic          halted_q, halted_d;
    trace_kind_e   reason_q, reason_d;
    logic [63:0]   instret_q, instret_d;
    logic [15:0]   drop_q, drop_d;
    logic          ovf_q, ovf_d;

    // unpack the flattened commit buses into one record per channel
    always_comb begin
        for (int i = 0; i < NCOMMIT; i++) begin
            chan_rec[i].pc        = XLEN_MAX'(cmt_pc[i*XLEN +: XLEN]);
            chan_rec[i].inst      = XLEN_MAX'(cmt_inst[i*XLEN +: XLEN]);
            chan_rec[i].kind      = rec_kind(cmt_brk[i], cmt_ivd[i]);
            chan_rec[i].gpr_wen   = cmt_gpr_wen[i];
            chan_rec[i].gpr_waddr = cmt_gpr_waddr[i*GPR_AW +: GPR_AW];
            chan_rec[i].gpr_wdata = XLEN_MAX'(cmt_gpr_wdata[i*XLEN +: XLEN]);
            chan_rec[i].csr_wen   = cmt_csr_wen[i];
            chan_rec[i].csr_waddr = cmt_csr_waddr[i*CSR_AW +: CSR_AW];
            chan_rec[i].csr_wdata = XLEN_MAX'(cmt_csr_wdata[i*XLEN +: XLEN]);
        end
    end

    // compact valid channels oldest-first, stopping after the first trapping channel
    always_comb begin
        int n;
        n         = 0;
        trap_seen = 1'b0;
        trap_kind = KIND_NORM;
        for (int s = 0; s < NCOMMIT; s++) wr_rec[s] = '0;
        for (int i = 0; i < NCOMMIT; i++) begin
            if (cmt_valid[i] && !trap_seen) begin
                for (int s = 0; s < NCOMMIT; s++)
                    if (s == n) wr_rec[s] = chan_rec[i];
                n++;
                trap_seen = chan_rec[i].kind != KIND_NORM;
                trap_kind = chan_rec[i].kind;
            end
        end
        n_keep = PW'(n);
    end

    // ready uses pre-pop occupancy, so a full FIFO that is draining still refuses this cycle
    assign cmt_ready = count <= CW'(DEPTH - NCOMMIT);
    assign active    = trace_en && !halted_q && (|cmt_valid);
    assign accept    = active && cmt_ready;
    assign dropping  = active && !cmt_ready;
    assign push_cnt  = accept ? n_keep : '0;

    dbg_trace_fifo #(
        .NCOMMIT (NCOMMIT),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .wr_rec_i   (wr_rec),
        .push_cnt_i (push_cnt),
        .pop_i      (out_valid && out_ready),
        .rd_rec_o   (head),
        .count_o    (count)
    );

    // next state: latch an accepted trap, count stores, saturate drops
    always_comb begin
        drop_sum  = {1'b0, drop_q} + 17'($countones(cmt_valid));
        halted_d  = halted_q | (accept & trap_seen);
        reason_d  = (accept && trap_seen) ? trap_kind : reason_q;
        instret_d = instret_q + 64'(push_cnt);
        drop_d    = !dropping ? drop_q : (drop_sum[16] ? 16'hFFFF : drop_sum[15:0]);
        ovf_d     = ovf_q | dropping;
    end

    // sticky halt/overflow and counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            halted_q  <= 1'b0;
            reason_q  <= KIND_NORM;
            instret_q <= '0;
            drop_q    <= '0;
            ovf_q     <= 1'b0;
        end else begin
            halted_q  <= halted_d;
            reason_q  <= reason_d;
            instret_q <= instret_d;
            drop_q    <= drop_d;
            ovf_q     <= ovf_d;
        end
    end

    // head fields are masked while empty because record storage is never reset
    assign out_valid     = count != '0;
    assign head_m        = out_valid ? head : '0;
    assign out_pc        = XLEN'(head_m.pc);
    assign out_inst      = XLEN'(head_m.inst);
    assign out_kind      = head_m.kind;
    assign out_gpr_wen   = head_m.gpr_wen;
    assign out_gpr_waddr = head_m.gpr_waddr;
    assign out_gpr_wdata = XLEN'(head_m.gpr_wdata);
    assign out_csr_wen   = head_m.csr_wen;
    assign out_csr_waddr = head_m.csr_waddr;
    assign out_csr_wdata = XLEN'(head_m.csr_wdata);
    assign halted        = halted_q;
    assign halt_reason   = reason_q;
    assign instret       = instret_q;
    assign drop_cnt      = drop_q;
    assign overflow      = ovf_q;

endmodule

// File: tb/tb_dbg_trace_buf.sv
// tb_dbg_trace_buf: scoreboard bench for the commit-trace buffer
module tb_dbg_trace_buf;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [1:0]  kind;
        logic        gpr_wen;
        logic [4:0]  gpr_waddr;
        logic [31:0] gpr_wdata;
        logic        csr_wen;
        logic [11:0] csr_waddr;
        logic [31:0] csr_wdata;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        trace_en = 1'b1;
    logic [1:0]  cmt_valid = '0;
    logic [63:0] cmt_pc = '0;
    logic [63:0] cmt_inst = '0;
    logic [1:0]  cmt_brk = '0;
    logic [1:0]  cmt_ivd = '0;
    logic [1:0]  cmt_gpr_wen = '0;
    logic [9:0]  cmt_gpr_waddr = '0;
    logic [63:0] cmt_gpr_wdata = '0;
    logic [1:0]  cmt_csr_wen = '0;
    logic [23:0] cmt_csr_waddr = '0;
    logic [63:0] cmt_csr_wdata = '0;
    logic        cmt_ready;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_pc, out_inst, out_gpr_wdata, out_csr_wdata;
    logic [1:0]  out_kind, halt_reason;
    logic        out_gpr_wen, out_csr_wen, halted, overflow;
    logic [4:0]  out_gpr_waddr;
    logic [11:0] out_csr_waddr;
    logic [63:0] instret;
    logic [15:0] drop_cnt;

    int          total = 0;
    int          bad = 0;

    rec_t        sb[$];
    int          exp_count = 0;
    logic        exp_halted = 1'b0;
    logic [1:0]  exp_reason = '0;
    logic [63:0] exp_instret = '0;
    logic [15:0] exp_drop = '0;
    logic        exp_ovf = 1'b0;
    int          m_pushed, m_popped, m_drop;
    rec_t        m_r, mon_got, mon_exp;

    dbg_trace_buf #(.NCOMMIT(2), .DEPTH(16), .XLEN(32)) dut (
        .clk(clk), .reset(reset), .trace_en(trace_en),
        .cmt_valid(cmt_valid), .cmt_pc(cmt_pc), .cmt_inst(cmt_inst),
        .cmt_brk(cmt_brk), .cmt_ivd(cmt_ivd),
        .cmt_gpr_wen(cmt_gpr_wen), .cmt_gpr_waddr(cmt_gpr_waddr), .cmt_gpr_wdata(cmt_gpr_wdata),
        .cmt_csr_wen(cmt_csr_wen), .cmt_csr_waddr(cmt_csr_waddr), .cmt_csr_wdata(cmt_csr_wdata),
        .cmt_ready(cmt_ready), .out_valid(out_valid), .out_ready(out_ready),
        .out_pc(out_pc), .out_inst(out_inst), .out_kind(out_kind),
        .out_gpr_wen(out_gpr_wen), .out_gpr_waddr(out_gpr_waddr), .out_gpr_wdata(out_gpr_wdata),
        .out_csr_wen(out_csr_wen), .out_csr_waddr(out_csr_waddr), .out_csr_wdata(out_csr_wdata),
        .halted(halted), .halt_reason(halt_reason), .instret(instret),
        .drop_cnt(drop_cnt), .overflow(overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    function automatic rec_t chan(input int i);
        rec_t r;
        r.pc        = cmt_pc[i*32 +: 32];
        r.inst      = cmt_inst[i*32 +: 32];
        r.kind      = cmt_ivd[i] ? 2'd2 : (cmt_brk[i] ? 2'd1 : 2'd0);
        r.gpr_wen   = cmt_gpr_wen[i];
        r.gpr_waddr = cmt_gpr_waddr[i*5 +: 5];
        r.gpr_wdata = cmt_gpr_wdata[i*32 +: 32];
        r.csr_wen   = cmt_csr_wen[i];
        r.csr_waddr = cmt_csr_waddr[i*12 +: 12];
        r.csr_wdata = cmt_csr_wdata[i*32 +: 32];
        return r;
    endfunction

    // reference model: decides what the buffer should do at each rising edge
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            sb.delete();
            exp_count = 0; exp_halted = 1'b0; exp_reason = '0;
            exp_instret = '0; exp_drop = '0; exp_ovf = 1'b0;
        end else begin
            m_pushed = 0;
            m_popped = (exp_count > 0 && out_ready) ? 1 : 0;
            if (trace_en && !exp_halted && cmt_valid != 2'b00) begin
                if (16 - exp_count >= 2) begin
                    for (int i = 0; i < 2; i++) begin
                        if (cmt_valid[i]) begin
                            m_r = chan(i);
                            sb.push_back(m_r);
                            m_pushed++;
                            if (m_r.kind != 2'd0) begin
                                exp_halted = 1'b1;
                                exp_reason = m_r.kind;
                                break;
                            end
                        end
                    end
                end else begin
                    m_drop = int'(exp_drop) + $countones(cmt_valid);
                    exp_drop = (m_drop > 65535) ? 16'hFFFF : 16'(m_drop);
                    exp_ovf = 1'b1;
                end
            end
            exp_instret = exp_instret + 64'(m_pushed);
            exp_count = exp_count + m_pushed - m_popped;
        end
    end

    // scoreboard check of every record the host consumes
    always @(negedge clk) begin
        if (reset && out_valid && out_ready) begin
            total++;
            mon_got = {out_pc, out_inst, out_kind, out_gpr_wen, out_gpr_waddr, out_gpr_wdata,
                       out_csr_wen, out_csr_waddr, out_csr_wdata};
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL pop_record got=%h exp=none", mon_got);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_got !== mon_exp) begin
                    bad++;
                    $display("FAIL pop_record got=%h exp=%h", mon_got, mon_exp);
                end
            end
        end
    end

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    // drives one commit group for exactly one cycle; called at posedge+1
    task automatic commit(input logic [1:0] v, input logic [31:0] pc0, input logic [31:0] inst0,
                          input logic [31:0] pc1, input logic [31:0] inst1,
                          input logic [1:0] brk, input logic [1:0] ivd);
        cmt_valid     = v;
        cmt_pc        = {pc1, pc0};
        cmt_inst      = {inst1, inst0};
        cmt_brk       = brk;
        cmt_ivd       = ivd;
        cmt_gpr_wen   = {inst1[11:7] != 5'd0, inst0[11:7] != 5'd0};
        cmt_gpr_waddr = {inst1[11:7], inst0[11:7]};
        cmt_gpr_wdata = {pc1 ^ 32'h80000000, pc0 ^ 32'h80000000};
        cmt_csr_wen   = {pc1[3], pc0[3]};
        cmt_csr_waddr = {pc1[15:4], pc0[15:4]};
        cmt_csr_wdata = {~inst1, ~inst0};
        @(posedge clk);
        #1;
        cmt_valid = '0;
        cmt_brk   = '0;
        cmt_ivd   = '0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int c = 0; c < 64 && exp_count != 0; c++) sync();
        out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || sb.size() != 0) begin
            bad++;
            $display("FAIL drain_empty got=%b/%0d exp=0/0", out_valid, sb.size());
        end
        sync();
    endtask

    task automatic do_reset();
        cmt_valid = '0;
        out_ready = 1'b0;
        trace_en  = 1'b1;
        reset     = 1'b0;
        sync();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if ({out_valid, cmt_ready, halted, halt_reason, instret, drop_cnt, overflow, out_pc} !==
            {1'b0, 1'b1, 1'b0, 2'd0, 64'd0, 16'd0, 1'b0, 32'd0}) begin
            bad++;
            $display("FAIL reset_state got=%b %b %b %0d %0d %0d %b %h exp=0 1 0 0 0 0 0 0",
                     out_valid, cmt_ready, halted, halt_reason, instret, drop_cnt, overflow, out_pc);
        end
        sync();
        reset = 1'b1;
    endtask

    task automatic test_single();
        commit(2'b01, 32'h80000000, 32'h00000413, 32'h0, 32'h0, 2'b00, 2'b00);
        @(negedge clk);
        total++;
        if ({out_valid, out_pc, out_kind, out_gpr_wen, out_gpr_waddr, out_gpr_wdata} !==
            {1'b1, 32'h80000000, 2'd0, 1'b1, 5'd8, 32'd0}) begin
            bad++;
            $display("FAIL single_head got=%b %h %0d %b %0d %h exp=1 80000000 0 1 8 0",
                     out_valid, out_pc, out_kind, out_gpr_wen, out_gpr_waddr, out_gpr_wdata);
        end
        total++;
        if (instret !== 64'd1) begin
            bad++;
            $display("FAIL single_instret got=%0d exp=1", instret);
        end
        sync();
        drain();
    endtask

    task automatic test_sparse_dual();
        commit(2'b10, 32'h0, 32'h0, 32'h80000004, 32'h00100093, 2'b00, 2'b00);
        @(negedge clk);
        total++;
        if (out_pc !== 32'h80000004 || out_inst !== 32'h00100093) begin
            bad++;
            $display("FAIL sparse_head got=%h/%h exp=80000004/00100093", out_pc, out_inst);
        end
        sync();
        drain();
        commit(2'b11, 32'h80000008, 32'h00200113, 32'h8000000C, 32'h00310193, 2'b00, 2'b00);
        drain();
        total++;
        if (instret !== 64'd4 || instret !== exp_instret) begin
            bad++;
            $display("FAIL dual_instret got=%0d exp=4", instret);
        end
    endtask

    task automatic test_trace_en();
        trace_en = 1'b0;
        commit(2'b11, 32'h80000100, 32'h00000013, 32'h80000104, 32'h00100073, 2'b10, 2'b00);
        trace_en = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || instret !== 64'd4 || halted !== 1'b0 || drop_cnt !== 16'd0) begin
            bad++;
            $display("FAIL trace_en_off got=%b %0d %b %0d exp=0 4 0 0", out_valid, instret, halted, drop_cnt);
        end
        sync();
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++)
            commit(2'b11, 32'h80001000 + 32'(k*8), 32'h00000513 + 32'(k << 7),
                   32'h80001004 + 32'(k*8), 32'h00000593 + 32'(k << 12), 2'b00, 2'b00);
        @(negedge clk);
        total++;
        if (cmt_ready !== 1'b0 || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL full_ready got=%b/%b exp=0/1", cmt_ready, out_valid);
        end
        sync();
        commit(2'b11, 32'h80002000, 32'h00100073, 32'h80002004, 32'h00000013, 2'b01, 2'b00);
        @(negedge clk);
        total++;
        if (drop_cnt !== 16'd2 || overflow !== 1'b1 || halted !== 1'b0 || instret !== exp_instret) begin
            bad++;
            $display("FAIL drop_group got=%0d %b %b %0d exp=2 1 0 %0d", drop_cnt, overflow, halted, instret, exp_instret);
        end
        sync();
        out_ready = 1'b1;
        sync();
        out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (cmt_ready !== 1'b0) begin
            bad++;
            $display("FAIL pop1_ready got=%b exp=0", cmt_ready);
        end
        sync();
        out_ready = 1'b1;
        sync();
        out_ready = 1'b0;
        @(negedge clk);
        total++;
        if (cmt_ready !== 1'b1) begin
            bad++;
            $display("FAIL pop2_ready got=%b exp=1", cmt_ready);
        end
        sync();
        drain();
    endtask

    task automatic test_trap();
        do_reset();
        commit(2'b11, 32'h8000000C, 32'h00100073, 32'h80000010, 32'h00000413, 2'b01, 2'b00);
        @(negedge clk);
        total++;
        if ({halted, halt_reason, out_kind, out_pc, instret} !== {1'b1, 2'd1, 2'd1, 32'h8000000C, 64'd1}) begin
            bad++;
            $display("FAIL trap_ch0 got=%b %0d %0d %h %0d exp=1 1 1 8000000c 1",
                     halted, halt_reason, out_kind, out_pc, instret);
        end
        sync();
        commit(2'b01, 32'h80000020, 32'h00000413, 32'h0, 32'h0, 2'b00, 2'b00);
        @(negedge clk);
        total++;
        if (instret !== 64'd1 || drop_cnt !== 16'd0 || overflow !== 1'b0 || halted !== 1'b1) begin
            bad++;
            $display("FAIL halted_ignore got=%0d %0d %b %b exp=1 0 0 1", instret, drop_cnt, overflow, halted);
        end
        sync();
        drain();
    endtask

    task automatic test_trap_ch1();
        do_reset();
        commit(2'b11, 32'h80000030, 32'h00000413, 32'h80000034, 32'h00100073, 2'b10, 2'b00);
        @(negedge clk);
        total++;
        if (instret !== 64'd2 || halted !== 1'b1 || halt_reason !== 2'd1 || out_kind !== 2'd0) begin
            bad++;
            $display("FAIL trap_ch1 got=%0d %b %0d %0d exp=2 1 1 0", instret, halted, halt_reason, out_kind);
        end
        sync();
        drain();
    endtask

    task automatic test_ivd();
        do_reset();
        commit(2'b01, 32'h80000040, 32'hFFFFFFFF, 32'h80000044, 32'h00000413, 2'b01, 2'b01);
        @(negedge clk);
        total++;
        if (out_kind !== 2'd2 || halt_reason !== 2'd2 || halted !== 1'b1 || instret !== 64'd1) begin
            bad++;
            $display("FAIL ivd_prio got=%0d %0d %b %0d exp=2 2 1 1", out_kind, halt_reason, halted, instret);
        end
        sync();
        drain();
    endtask

    task automatic test_async_reset();
        do_reset();
        commit(2'b11, 32'h80000050, 32'h00000413, 32'h80000054, 32'h00000493, 2'b00, 2'b00);
        commit(2'b11, 32'h80000058, 32'h00000513, 32'h8000005C, 32'h00000593, 2'b00, 2'b00);
        commit(2'b01, 32'h80000060, 32'h00100073, 32'h0, 32'h0, 2'b01, 2'b00);
        @(negedge clk);
        total++;
        if (halted !== 1'b1 || instret !== 64'd5 || cmt_ready !== 1'b1) begin
            bad++;
            $display("FAIL pre_reset got=%b %0d %b exp=1 5 1", halted, instret, cmt_ready);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        total++;
        if ({out_valid, instret, halted, halt_reason, cmt_ready, out_pc} !==
            {1'b0, 64'd0, 1'b0, 2'd0, 1'b1, 32'd0}) begin
            bad++;
            $display("FAIL async_reset got=%b %0d %b %0d %b %h exp=0 0 0 0 1 0",
                     out_valid, instret, halted, halt_reason, cmt_ready, out_pc);
        end
        sync();
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || cmt_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_reset got=%b/%b exp=0/1", out_valid, cmt_ready);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sparse_dual();
        test_trace_en();
        test_backpressure();
        test_trap();
        test_trap_ch1();
        test_ivd();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dbg_trace_buf.md
Name: dbg_trace_buf

Overview:
- Parametrised commit-trace buffer for the NPC core.
- Captures up to NCOMMIT retired instructions per cycle: pc, inst, GPR write, CSR write and ebreak/invalid flags.
- Packs the records in order into a FIFO and drains them one per cycle over a valid/ready port to the simulation debugger.
- Keeps a retired-instruction count, a drop count and a sticky halt state for ebreak or invalid instruction, so the host no longer has to sample the core every cycle.

Parameters:
- NCOMMIT, 2, commit channels per cycle. Range 1..4; channel 0 is oldest.
- DEPTH, 16, FIFO entries. Power of two, DEPTH >= 2*NCOMMIT.
- XLEN, 32, width of pc, inst and data.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- trace_en  in  1  when low, commits are ignored: not stored, not counted, no drop.
- cmt_valid  in  NCOMMIT  per-channel retire strobe.
- cmt_pc  in  NCOMMIT*XLEN  retired pc.
- cmt_inst  in  NCOMMIT*XLEN  retired instruction word.
- cmt_brk  in  NCOMMIT  retired instruction is ebreak.
- cmt_ivd  in  NCOMMIT  retired instruction is invalid.
- cmt_gpr_wen  in  NCOMMIT  GPR write enable.
- cmt_gpr_waddr  in  NCOMMIT*5  GPR index.
- cmt_gpr_wdata  in  NCOMMIT*XLEN  GPR data.
- cmt_csr_wen  in  NCOMMIT  CSR write enable.
- cmt_csr_waddr  in  NCOMMIT*12  CSR address.
- cmt_csr_wdata  in  NCOMMIT*XLEN  CSR data.
- cmt_ready  out  1  buffer can accept a full commit group this cycle.
- out_valid  out  1  a record is available at the head.
- out_ready  in  1  host consumes the head record.
- out_pc, out_inst  out  XLEN each  head record pc and instruction.
- out_kind  out  2  0 normal, 1 ebreak, 2 invalid.
- out_gpr_wen, out_gpr_waddr, out_gpr_wdata  out  1/5/XLEN  head record GPR write.
- out_csr_wen, out_csr_waddr, out_csr_wdata  out  1/12/XLEN  head record CSR write.
- halted  out  1  sticky halt flag.
- halt_reason  out  2  same encoding as out_kind.
- instret  out  64  count of accepted commits.
- drop_cnt  out  16  count of dropped commits, saturating.
- overflow  out  1  sticky: at least one commit was dropped.

Behaviour:
- Reset (reset=0, async): clears FIFO pointers and count, halted, halt_reason, instret, drop_cnt and overflow. All outputs read 0 except cmt_ready, which reads 1. Record storage is not reset.
- cmt_ready is combinational: (DEPTH - count) >= NCOMMIT. It uses count before any same-cycle pop, so it is conservative when full and popping.
- A group is active when trace_en=1, halted=0 and any cmt_valid bit is set.
- Active and cmt_ready=1: the group is accepted.
  - Valid channels are compacted in ascending channel order into consecutive FIFO slots; sparse masks such as 2'b10 write one entry.
  - Each channel's kind: 2 if cmt_ivd, else 1 if cmt_brk, else 0. ivd has priority over brk.
  - Trap truncation: take the lowest valid channel k with kind != 0. Channels 0..k are stored; channels above k are discarded and not counted as drops.
- Active and cmt_ready=0: nothing is stored.
  - drop_cnt += popcount(cmt_valid), saturating at 0xFFFF.
  - overflow is set.
  - Traps inside a dropped group are not recognised.
- Halt: when an accepted group contains a trap, halted=1 and halt_reason=kind of channel k take effect the next cycle. Both hold until reset. Draining continues while halted.
- instret += number of records stored; 64-bit, wraps.
- FIFO:
  - out_* are driven from the head entry. An entry pushed in cycle t is visible no earlier than cycle t+1; there is no bypass when empty.
  - A pop occurs when out_valid && out_ready.
  - Push and pop in the same cycle: count' = count + pushed - popped.
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
  - out_* are stable while out_valid=1 and out_ready=0.
- Reset asserted mid-operation discards all buffered records immediately.

Decomposition:
- Package dbg_pkg holds:
  - trace_rec_t struct: pc, inst, kind, gpr_wen, gpr_waddr, gpr_wdata, csr_wen, csr_waddr, csr_wdata.
  - trace_kind_e enum: KIND_NORM=0, KIND_EBRK=1, KIND_IVD=2.
  - constants GPR_AW=5 and CSR_AW=12.
- Sub-module dbg_trace_fifo: multi-write (NCOMMIT ports plus a push count), single-read FIFO of trace_rec_t with count.
- Compaction, trap truncation, counters and the halt flag stay in dbg_trace_buf.

Test Plan:
- Single commit: NCOMMIT=2, cmt_valid=2'b01, pc=0x80000000, inst=0x00000413, gpr x8=0 -> one record next cycle, kind=0, instret=1.
- Sparse and dual commit:
  - cmt_valid=2'b10 with pc1=0x80000004 -> one entry with pc 0x80000004.
  - Then 2'b11 with pcs 0x8, 0xC -> pops occur in order 0x8, 0xC; instret=3.
- Trap truncation: cmt_valid=2'b11, ch0 ebreak (0x00100073), ch1 pc=0x80000010 -> only ch0 stored with kind=1; halted=1 and halt_reason=1 next cycle; a later commit is ignored and drop_cnt=0.
- ivd priority: ch0 with cmt_brk=1 and cmt_ivd=1 -> kind=2, halt_reason=2.
- Backpressure, DEPTH=16, out_ready=0:
  - 8 dual commits -> count=16, cmt_ready=0.
  - A 2'b11 group forced in anyway -> drop_cnt=2 and overflow=1.
  - One pop -> count=15, cmt_ready still 0.
  - Second pop -> count=14, cmt_ready=1.
- Async reset mid-drain with 5 buffered entries -> out_valid=0, instret=0, halted=0 without waiting for a clock edge; cmt_ready=1.
